int2flt_core: RTL and testbench
===============================

# int2flt_core

Hardwired converter from a 16-bit two's-complement integer to a 16-bit sign/exponent/mantissa float with round-to-nearest-even. It is a start/done-controlled top-level engine. It owns a byte-wide data memory: operands are preloaded into the memory and results are read back from it. Benches drive the memory through hierarchy, so no data ports exist.

## Interface
- Parameters: none.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high. Returns the FSM to IDLE and clears done.
- start  input  1  request. Pulse high for at least 1 cycle; conversion begins after start returns low.
- done  output  1  result valid in memory. Held high until the next start.
- Internal memory instance `data_mem1`, array `mem_core`: 256 x 8 bits, asynchronous read, synchronous write.
  - Bytes 1:0 hold the input, big byte at address 1.
  - Bytes 3:2 hold the output, big byte at address 3.
  - Memory is not cleared by reset.

## Operation
- Output format:
  - bit 15 = sign.
  - bits 14:10 = exponent, bias 15.
  - bits 9:0 = fraction, hidden leading 1.
  - No denormals, infinity or NaN.
- sign = in[15]. mag = sign ? (~in + 1) : in, 16-bit unsigned, so -32768 gives 0x8000.
- mag == 0: result = {sign, 15'b0}. For an input of 0 this is 0x0000.
- Normalize: start with exp = 30 and shift mag left one bit per cycle, decrementing exp, until mag[15] = 1.
- Rounding:
  - m = mag[15:5] (11 bits), g = mag[4], s = |mag[3:0], l = mag[5].
  - Round up (m + 1) iff g & (l | s).
  - If m overflows to 12'h800, set exp = exp + 1 and fraction = 0.
  - Otherwise fraction = m[9:0].
  - Max exp is 30, so the result never overflows.
- FSM states:
  - IDLE: on start=1, clear done and go to ARMED.
  - ARMED: wait while start=1. When start=0, go to RD_LO.
  - RD_LO: latch mem[0].
  - RD_HI: latch mem[1].
  - ABS: compute sign, mag, exp=30. If mag==0, form the zero result and go to WR_LO.
  - NORM: shift/decrement while mag[15]==0 (0–15 cycles).
  - ROUND: compute the rounded result.
  - WR_LO: write mem[2] = res[7:0].
  - WR_HI: write mem[3] = res[15:8].
  - FIN: set done=1, then go to IDLE.
- start asserted outside IDLE is ignored.

## Timing
- Reset values: done=0, state=IDLE. Internal registers are 0.
- Latency from the first cycle with start=0 in ARMED to done=1: 7 + N cycles, where N is the number of normalize shifts (0..15). Maximum is 22 cycles.
- mem[3:2] are stable from the cycle after WR_HI. done rises one cycle later.
- done stays high across IDLE until start is sampled high. It drops the following cycle.
- Reset mid-operation: next state is IDLE and done=0. Result bytes may be partially written. Input bytes are untouched.
- Simultaneous reset and start: reset wins and start is ignored that cycle.
- The bench preloads mem[1:0] while start is high. Input bytes are sampled only in RD_LO/RD_HI.

## Configuration
- INT2FLT_ROUND_EN defined: round-to-nearest-even as specified above.
- INT2FLT_ROUND_EN undefined:
  - Truncate: fraction = mag[14:5].
  - No increment and no exponent bump.
  - Latency is unchanged (ROUND state is still traversed).
- Bench/regression builds define INT2FLT_ROUND_EN.

## Test plan
- Preload 0x0001 and pulse start for 2 cycles -> mem[3:2] = 0x3C00, done within 22 cycles. Preload 0xFFFF (-1) -> 0xBC00.
- Edge values:
  - 0x0000 -> 0x0000.
  - 0x8000 (-32768) -> 0xF800.
  - 3 -> 0x4200.
  - 12 -> 0x4A00.
- Rounding carry:
  - 32767 -> 0x7800.
  - 8191 -> 0x7000.
  - -8191 -> 0xF000.
- Ties:
  - 2049 (0x0801) -> 0x6800 (tie, even, no round).
  - 2051 (0x0803) -> 0x6802 (tie, odd, round up).
- Reset asserted during NORM -> done=0 next cycle, FSM in IDLE. A new start then converts correctly.
- Back-to-back: 72 random inputs, each start pulse issued after done -> every result matches the mathematical model. done drops one cycle after each start.

Source files
------------

// File: rtl/int2flt_core.sv
// int2flt_core: 16-bit integer to 16-bit float converter with an owned byte memory.
// Define INT2FLT_ROUND_EN for round-to-nearest-even; otherwise the fraction truncates.

module int2flt_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem_core [256];

  always_ff @(posedge clk) begin
    if (we) mem_core[addr] <= wdata;
  end

  assign rdata = mem_core[addr];

endmodule

module int2flt_core (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  typedef enum logic [3:0] {
    IDLE, ARMED, RD_LO, RD_HI, ABS,
    NORM, ROUND, WR_LO, WR_HI, FIN
  } state_t;

  state_t      state;
  logic [7:0]  in_lo;
  logic [15:0] word;
  logic        sign;
  logic [15:0] mag;
  logic [4:0]  expo;
  logic [15:0] res;

  logic [7:0]  addr;
  logic        we;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  logic [15:0] mag_c;
  logic [4:0]  exp_r;
  logic [9:0]  frac_r;

  int2flt_mem data_mem1 (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_comb begin
    addr  = 8'd0;
    we    = 1'b0;
    wdata = res[7:0];
    unique case (1'b1)
      state == RD_LO: addr = 8'd0;
      state == RD_HI: addr = 8'd1;
      state == WR_LO: begin
        addr = 8'd2;
        we   = 1'b1;
      end
      state == WR_HI: begin
        addr  = 8'd3;
        we    = 1'b1;
        wdata = res[15:8];
      end
      default: addr = 8'd0;
    endcase
  end

  assign word  = {rdata, in_lo};
  assign mag_c = word[15] ? (~word + 16'd1) : word;

`ifdef INT2FLT_ROUND_EN
  logic [10:0] m;
  logic        g;
  logic        s;
  logic        l;
  logic        up;
  logic [11:0] m_r;
  logic        unused_bit;

  assign m   = mag[15:5];
  assign g   = mag[4];
  assign s   = |mag[3:0];
  assign l   = mag[5];
  assign up  = g & (l | s);
  assign m_r = {1'b0, m} + {11'd0, up};
  assign unused_bit = m_r[10];

  // Carry out of the 11-bit significand renormalizes to 1.0 x 2^(e+1)
  always_comb begin
    exp_r  = expo;
    frac_r = m_r[9:0];
    if (m_r[11]) begin
      exp_r  = expo + 5'd1;
      frac_r = 10'd0;
    end
  end
`else
  logic [5:0] unused_bits;

  assign unused_bits = {mag[15], mag[4:0]};
  assign exp_r  = expo;
  assign frac_r = mag[14:5];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      in_lo <= 8'd0;
      sign  <= 1'b0;
      mag   <= 16'd0;
      expo  <= 5'd0;
      res   <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            done  <= 1'b0;
            state <= ARMED;
          end
        end
        ARMED: begin
          if (!start) state <= RD_LO;
        end
        RD_LO: begin
          in_lo <= rdata;
          state <= RD_HI;
        end
        RD_HI: begin
          sign  <= word[15];
          mag   <= mag_c;
          expo  <= 5'd30;
          state <= ABS;
        end
        ABS: begin
          if (mag == 16'd0) begin
            res   <= {sign, 15'd0};
            state <= WR_LO;
          end else if (mag[15]) begin
            state <= ROUND;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          mag  <= mag << 1;
          expo <= expo - 5'd1;
          if (mag[14]) state <= ROUND;
        end
        ROUND: begin
          res   <= {sign, exp_r, frac_r};
          state <= WR_LO;
        end
        WR_LO: state <= WR_HI;
        WR_HI: state <= FIN;
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int2flt_core.sv
// tb_int2flt_core: directed and random conversions against an arithmetic model.
// Memory is preloaded and read back through the DUT hierarchy.

module tb_int2flt_core;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  int2flt_core dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int msb_pos(input int a);
    int p = 0;
    for (int i = 0; i < 17; i++)
      if (a >= (1 << i)) p = i;
    return p;
  endfunction

  // Value-level model: scale to [1,2), round the dropped remainder to even
  function automatic logic [15:0] ref_conv(input logic [15:0] v);
    int x, a, p, e, q, sh, rem, half;
    logic sgn;
    logic [9:0] f;
    logic [4:0] e5;
    x = int'($signed(v));
    sgn = (x < 0);
    a = sgn ? -x : x;
    if (a == 0) return {sgn, 15'd0};
    p = msb_pos(a);
    e = 15 + p;
    if (p <= 10) begin
      q = a << (10 - p);
    end else begin
      sh = p - 10;
      q = a >> sh;
      rem = a - (q << sh);
      half = 1 << (sh - 1);
`ifdef INT2FLT_ROUND_EN
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (q == 2048) begin
        q = 1024;
        e = e + 1;
      end
`endif
    end
    f = 10'(q - 1024);
    e5 = 5'(e);
    return {sgn, e5, f};
  endfunction

  function automatic int ref_lat(input logic [15:0] v);
    int x, a;
    x = int'($signed(v));
    a = (x < 0) ? -x : x;
    if (a == 0) return 6;
    return 7 + (15 - msb_pos(a));
  endfunction

  task automatic run_conv(input logic [15:0] v,
                          input logic [15:0] expv,
                          input string tag);
    int lat;
    logic [15:0] got;
    @(posedge clk);
    #1;
    start = 1'b1;
    dut.data_mem1.mem_core[0] = v[7:0];
    dut.data_mem1.mem_core[1] = v[15:8];
    @(posedge clk);
    #1;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    lat = 0;
    repeat (40) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
    if (!done) lat = 99;
    check({tag, "_lat"}, 32'(lat), 32'(ref_lat(v)));
    got = {dut.data_mem1.mem_core[3], dut.data_mem1.mem_core[2]};
    check({tag, "_res"}, 32'(got), 32'(expv));
    check({tag, "_in"},
          32'({dut.data_mem1.mem_core[1], dut.data_mem1.mem_core[0]}),
          32'(v));
  endtask

  task automatic run_dir(input logic [15:0] v,
                         input logic [15:0] spec_val,
                         input string tag);
`ifdef INT2FLT_ROUND_EN
    run_conv(v, spec_val, tag);
`else
    run_conv(v, ref_conv(v), {tag, "_", $sformatf("%h", spec_val)});
`endif
  endtask

  initial begin
    logic [15:0] v;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dut.state), 32'd0);
    reset = 1'b0;

    run_dir(16'h0001, 16'h3C00, "one");
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 32'(done), 32'd1);
    run_dir(16'hFFFF, 16'hBC00, "neg_one");
    run_dir(16'h0000, 16'h0000, "zero");
    run_dir(16'h8000, 16'hF800, "min");
    run_dir(16'd3, 16'h4200, "three");
    run_dir(16'd12, 16'h4A00, "twelve");
    run_dir(16'd32767, 16'h7800, "max");
    run_dir(16'd8191, 16'h7000, "p8191");
    run_dir(16'hE001, 16'hF000, "m8191");
    run_dir(16'h0801, 16'h6800, "tie_even");
    run_dir(16'h0803, 16'h6802, "tie_odd");

    // Abort a long normalization, then confirm a fresh conversion works
    @(posedge clk);
    #1;
    start = 1'b1;
    dut.data_mem1.mem_core[0] = 8'h01;
    dut.data_mem1.mem_core[1] = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_state_norm", 32'(dut.state), 32'd5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'd0);
    check("mid_rst_in",
          32'({dut.data_mem1.mem_core[1], dut.data_mem1.mem_core[0]}),
          32'h0001);

    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_state", 32'(dut.state), 32'd0);
    run_dir(16'd3, 16'h4200, "after_rst");

    for (int i = 0; i < 72; i++) begin
      v = 16'($urandom);
      v = v >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) v = ~v + 16'd1;
      run_conv(v, ref_conv(v), $sformatf("rnd%0d_%h", i, v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
